bus_burst_ctrl: RTL and testbench

Downstream consumer of the 4-way arbiter's grant outputs. It turns a one-hot grant into an owned burst on a single shared data bus. It latches the granted master, then streams that master's beats under slave backpressure. When the burst ends it pulses a per-master done so the master can drop its request and the arbiter can re-arbitrate.

---
 rtl/bus_burst_pkg.sv | 27 ++
 rtl/beat_counter.sv | 34 +++
 rtl/bus_burst_ctrl.sv | 154 +++++++++++++++
 tb/tb_bus_burst_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/bus_burst_pkg.sv
// rtl/bus_burst_pkg.sv - shared types, widths and grant helpers for bus_burst_ctrl
package bus_burst_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int OWNER_W    = 2;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_LEN_W  = 4;

    function automatic logic onehot4(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [OWNER_W-1:0] enc4(input logic [3:0] v);
        logic [OWNER_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) idx = OWNER_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/beat_counter.sv
// rtl/beat_counter.sv - load/decrement beats-remaining counter with zero flag
module beat_counter #(
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LEN_W-1:0] load_val,
    input  logic             dec,
    output logic [LEN_W-1:0] count,
    output logic             zero
);

    logic [LEN_W-1:0] count_q, count_d;

    // Decrement is gated at zero so the counter can never wrap.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/bus_burst_ctrl.sv
// rtl/bus_burst_ctrl.sv - turns a one-hot arbiter grant into an owned burst on a shared bus
module bus_burst_ctrl
    import bus_burst_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               gnt3,
    input  logic               gnt2,
    input  logic               gnt1,
    input  logic               gnt0,
    input  logic [DATA_W-1:0]  mdata3,
    input  logic [DATA_W-1:0]  mdata2,
    input  logic [DATA_W-1:0]  mdata1,
    input  logic [DATA_W-1:0]  mdata0,
    input  logic [LEN_W-1:0]   mlen3,
    input  logic [LEN_W-1:0]   mlen2,
    input  logic [LEN_W-1:0]   mlen1,
    input  logic [LEN_W-1:0]   mlen0,
    input  logic               bus_ready,
    output logic               bus_valid,
    output logic [DATA_W-1:0]  bus_data,
    output logic               bus_last,
    output logic [OWNER_W-1:0] bus_owner,
    output logic               busy,
    output logic               done3,
    output logic               done2,
    output logic               done1,
    output logic               done0,
    output logic               gnt_err
);

    state_e               state_q, state_d;
    logic [OWNER_W-1:0]   owner_q, owner_d;
    logic                 valid_q, valid_d;
    logic                 last_q, last_d;
    logic                 busy_q, busy_d;
    logic [3:0]           done_q, done_d;
    logic                 gnt_err_q, gnt_err_d;

    logic [3:0]           gnt;
    logic [OWNER_W-1:0]   gnt_idx;
    logic [LEN_W-1:0]     mlen_sel;
    logic                 cnt_load, cnt_dec, cnt_zero;
    logic [LEN_W-1:0]     cnt_val;

    assign gnt     = {gnt3, gnt2, gnt1, gnt0};
    assign gnt_idx = enc4(gnt);

    always_comb begin
        case (gnt_idx)
            2'd0:    mlen_sel = mlen0;
            2'd1:    mlen_sel = mlen1;
            2'd2:    mlen_sel = mlen2;
            default: mlen_sel = mlen3;
        endcase
    end

    beat_counter #(.LEN_W(LEN_W)) u_beat_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (mlen_sel),
        .dec      (cnt_dec),
        .count    (cnt_val),
        .zero     (cnt_zero)
    );

    // Outputs are computed from the next state so every one of them leaves a flop.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        valid_d   = 1'b0;
        last_d    = 1'b0;
        done_d    = 4'd0;
        gnt_err_d = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (onehot4(gnt)) begin
                    owner_d  = gnt_idx;
                    cnt_load = 1'b1;
                    state_d  = ST_XFER;
                    valid_d  = 1'b1;
                    last_d   = (mlen_sel == '0);
                end else if (gnt != 4'd0) begin
                    gnt_err_d = 1'b1;
                end
            end
            ST_XFER: begin
                valid_d = 1'b1;
                last_d  = last_q;
                if (bus_ready) begin
                    if (cnt_zero) begin
                        state_d         = ST_DONE;
                        valid_d         = 1'b0;
                        last_d          = 1'b0;
                        done_d[owner_q] = 1'b1;
                    end else begin
                        cnt_dec = 1'b1;
                        last_d  = (cnt_val == LEN_W'(1));
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 4'd0;
            gnt_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            gnt_err_q <= gnt_err_d;
        end
    end

    always_comb begin
        case (owner_q)
            2'd0:    bus_data = mdata0;
            2'd1:    bus_data = mdata1;
            2'd2:    bus_data = mdata2;
            default: bus_data = mdata3;
        endcase
    end

    assign bus_valid = valid_q;
    assign bus_last  = last_q;
    assign bus_owner = owner_q;
    assign busy      = busy_q;
    assign {done3, done2, done1, done0} = done_q;
    assign gnt_err   = gnt_err_q;

endmodule

// File: tb/tb_bus_burst_ctrl.sv
// tb/tb_bus_burst_ctrl.sv - directed table-driven bench for bus_burst_ctrl
module tb_bus_burst_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] gnt;
    logic [7:0] mdata [4];
    logic [3:0] mlen  [4];
    logic       bus_ready;
    logic       bus_valid, bus_last, busy, gnt_err;
    logic [7:0] bus_data;
    logic [1:0] bus_owner;
    logic       done3, done2, done1, done0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bus_burst_ctrl #(.DATA_W(8), .LEN_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .gnt3      (gnt[3]),
        .gnt2      (gnt[2]),
        .gnt1      (gnt[1]),
        .gnt0      (gnt[0]),
        .mdata3    (mdata[3]),
        .mdata2    (mdata[2]),
        .mdata1    (mdata[1]),
        .mdata0    (mdata[0]),
        .mlen3     (mlen[3]),
        .mlen2     (mlen[2]),
        .mlen1     (mlen[1]),
        .mlen0     (mlen[0]),
        .bus_ready (bus_ready),
        .bus_valid (bus_valid),
        .bus_data  (bus_data),
        .bus_last  (bus_last),
        .bus_owner (bus_owner),
        .busy      (busy),
        .done3     (done3),
        .done2     (done2),
        .done1     (done1),
        .done0     (done0),
        .gnt_err   (gnt_err)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  gnt;
        logic [15:0] mlen;
        logic        ready;
        logic        v;
        logic        l;
        logic [1:0]  o;
        logic        b;
        logic [3:0]  d;
        logic        e;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] g, input logic [15:0] ml, input logic y,
                       input logic v, input logic l, input logic [1:0] o, input logic b,
                       input logic [3:0] d, input logic e);
        vec_t t;
        t.rst = r; t.gnt = g; t.mlen = ml; t.ready = y;
        t.v = v; t.l = l; t.o = o; t.b = b; t.d = d; t.e = e;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int row, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    logic [7:0] mdata_ref [4];

    initial begin
        mdata_ref[0] = 8'hA5; mdata_ref[1] = 8'h3C;
        mdata_ref[2] = 8'h5A; mdata_ref[3] = 8'hC3;
        for (int i = 0; i < 4; i++) begin
            mdata[i] = mdata_ref[i];
            mlen[i]  = 4'd0;
        end
        rst = 1'b1; gnt = 4'd0; bus_ready = 1'b0;

        //   rst  gnt     mlen      rdy   v  l  o  b  done   err
        add(1, 4'b0000, 16'h0000, 0,   0, 0, 0, 0, 4'h0, 0);
        add(1, 4'b0001, 16'h0000, 1,   0, 0, 0, 0, 4'h0, 0);
        add(0, 4'b0000, 16'h0000, 1,   0, 0, 0, 0, 4'h0, 0);
        // single beat from master 0
        add(0, 4'b0001, 16'h0000, 1,   1, 1, 0, 1, 4'h0, 0);
        add(0, 4'b0000, 16'h0000, 1,   0, 0, 0, 1, 4'h1, 0);
        add(0, 4'b0000, 16'h0000, 1,   0, 0, 0, 0, 4'h0, 0);
        // four beats from master 2 under backpressure
        add(0, 4'b0100, 16'h0300, 0,   1, 0, 2, 1, 4'h0, 0);
        add(0, 4'b0000, 16'h0000, 0,   1, 0, 2, 1, 4'h0, 0);
        add(0, 4'b0000, 16'h0000, 0,   1, 0, 2, 1, 4'h0, 0);
        add(0, 4'b0000, 16'h0000, 1,   1, 0, 2, 1, 4'h0, 0);
        add(0, 4'b0000, 16'h0000, 1,   1, 0, 2, 1, 4'h0, 0);
        add(0, 4'b0000, 16'h0000, 0,   1, 0, 2, 1, 4'h0, 0);
        add(0, 4'b0000, 16'h0000, 0,   1, 0, 2, 1, 4'h0, 0);
        add(0, 4'b0000, 16'h0000, 1,   1, 1, 2, 1, 4'h0, 0);
        add(0, 4'b0000, 16'h0000, 0,   1, 1, 2, 1, 4'h0, 0);
        add(0, 4'b0000, 16'h0000, 1,   0, 0, 2, 1, 4'h4, 0);
        add(0, 4'b0000, 16'h0000, 1,   0, 0, 2, 0, 4'h0, 0);
        // grant churn: master 1 keeps the bus while gnt0 rises
        add(0, 4'b0010, 16'h0020, 1,   1, 0, 1, 1, 4'h0, 0);
        add(0, 4'b0001, 16'h0020, 1,   1, 0, 1, 1, 4'h0, 0);
        add(0, 4'b0001, 16'h0020, 1,   1, 1, 1, 1, 4'h0, 0);
        add(0, 4'b0001, 16'h0020, 1,   0, 0, 1, 1, 4'h2, 0);
        add(0, 4'b0001, 16'h0020, 1,   0, 0, 1, 0, 4'h0, 0);
        add(0, 4'b0001, 16'h0020, 1,   1, 1, 0, 1, 4'h0, 0);
        add(0, 4'b0000, 16'h0020, 1,   0, 0, 0, 1, 4'h1, 0);
        add(0, 4'b0000, 16'h0020, 1,   0, 0, 0, 0, 4'h0, 0);
        // illegal double grant
        add(0, 4'b0011, 16'h0000, 1,   0, 0, 0, 0, 4'h0, 1);
        add(0, 4'b0000, 16'h0000, 1,   0, 0, 0, 0, 4'h0, 0);
        // reset on beat 2 of a 5-beat burst, then a clean restart
        add(0, 4'b0001, 16'h0004, 1,   1, 0, 0, 1, 4'h0, 0);
        add(0, 4'b0000, 16'h0004, 1,   1, 0, 0, 1, 4'h0, 0);
        add(1, 4'b0000, 16'h0004, 1,   0, 0, 0, 0, 4'h0, 0);
        add(0, 4'b0000, 16'h0004, 1,   0, 0, 0, 0, 4'h0, 0);
        add(0, 4'b0000, 16'h0004, 1,   0, 0, 0, 0, 4'h0, 0);
        add(0, 4'b0100, 16'h0004, 1,   1, 1, 2, 1, 4'h0, 0);
        add(0, 4'b0000, 16'h0004, 1,   0, 0, 2, 1, 4'h4, 0);
        add(0, 4'b0000, 16'h0004, 1,   0, 0, 2, 0, 4'h0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst = vecs[i].rst; gnt = vecs[i].gnt; bus_ready = vecs[i].ready;
            for (int m = 0; m < 4; m++) mlen[m] = vecs[i].mlen[4*m +: 4];
            @(posedge clk);
            #1;
            chk("bus_valid", i, {7'd0, bus_valid}, {7'd0, vecs[i].v});
            chk("bus_last",  i, {7'd0, bus_last},  {7'd0, vecs[i].l});
            chk("bus_owner", i, {6'd0, bus_owner}, {6'd0, vecs[i].o});
            chk("busy",      i, {7'd0, busy},      {7'd0, vecs[i].b});
            chk("done",      i, {4'd0, done3, done2, done1, done0}, {4'd0, vecs[i].d});
            chk("gnt_err",   i, {7'd0, gnt_err},   {7'd0, vecs[i].e});
            if (vecs[i].v) chk("bus_data", i, bus_data, mdata_ref[vecs[i].o]);
        end

        // 16-beat burst from master 3 with ready held high
        begin
            int beats, lasts, dones, cyc;
            logic bad_owner;
            beats = 0; lasts = 0; dones = 0; cyc = 0; bad_owner = 1'b0;
            @(negedge clk);
            gnt = 4'b1000; mlen[3] = 4'd15; bus_ready = 1'b1;
            @(negedge clk);
            gnt = 4'b0000;
            while (busy && cyc < 40) begin
                if (bus_valid && bus_ready) begin
                    beats++;
                    if (bus_owner != 2'd3) bad_owner = 1'b1;
                    if (bus_last) begin
                        lasts++;
                        chk("max_last_beat_idx", beats, 8'(beats), 8'd16);
                    end
                end
                if (done3) dones++;
                cyc++;
                @(negedge clk);
            end
            chk("max_timeout",  cyc,  {7'd0, busy}, 8'd0);
            chk("max_beats",    0, 8'(beats), 8'd16);
            chk("max_lasts",    0, 8'(lasts), 8'd1);
            chk("max_done3",    0, 8'(dones), 8'd1);
            chk("max_owner_ok", 0, {7'd0, bad_owner}, 8'd0);
            chk("max_cycles",   0, 8'(cyc), 8'd17);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
